udc_sequencer: RTL

//  Run/pause/direction controller for the 4-bit up/down counter datapath.

---
 rtl/udc_pkg.sv | 20 ++
 rtl/btn_conditioner.sv | 55 +++++
 rtl/udc_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/udc_pkg.sv
// Shared encodings for the up/down counter sequencer: FSM state codes and limit modes.
package udc_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [1:0] MODE_WRAP   = 2'b00;
  localparam logic [1:0] MODE_BOUNCE = 2'b01;
  localparam logic [1:0] MODE_STOP   = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    PAUSE = ST_PAUSE,
    DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/btn_conditioner.sv
// Raw push-button to one-cycle press pulse: 2-FF synchronizer, stability debouncer,
// rising-edge detector on the debounced level.
module btn_conditioner #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = btn_raw;
    sync2_d  = sync1_q;
    prev_d   = stable_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    // cnt_q counts consecutive synced samples that disagree with the accepted level
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign press = stable_q & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/udc_sequencer.sv
// Run/pause/direction controller for a WIDTH-bit up/down counter: button conditioning,
// step-tick prescaler and the IDLE/RUN/PAUSE/DONE sequencer with wrap/bounce/stop limits.
module udc_sequencer
  import udc_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_run,
  input  logic             btn_dir,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] count_val,
  output logic             step,
  output logic             up,
  output logic             clear,
  output logic             busy,
  output logic [1:0]       state_o
);

  localparam int PW = $clog2(TICK_DIV);

  logic run_p, dir_p;

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_run_btn (
    .clk     (clock),
    .rst     (reset),
    .btn_raw (btn_run),
    .press   (run_p)
  );

  btn_conditioner #(.DEB_CYCLES(DEB_CYCLES)) u_dir_btn (
    .clk     (clock),
    .rst     (reset),
    .btn_raw (btn_dir),
    .press   (dir_p)
  );

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            dir_q, dir_d;
  logic            step_q, step_d;
  logic            up_q, up_d;
  logic            clear_q, clear_d;

  logic            tick;
  logic            at_limit;
  logic            step_dir;
  logic [1:0]      mode_eff;

  always_comb begin
    mode_eff = (mode == MODE_BOUNCE || mode == MODE_STOP) ? mode : MODE_WRAP;
    at_limit = (count_val == {WIDTH{dir_q}});
    tick     = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));

    state_d  = state_q;
    presc_d  = presc_q;
    step_d   = 1'b0;
    clear_d  = 1'b0;
    step_dir = dir_q;
    dir_d    = dir_q ^ (dir_p && (state_q != DONE));

    if (state_q == RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end

    case (state_q)
      IDLE: begin
        if (run_p) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        if (run_p) begin
          state_d = PAUSE;
        end else if (tick) begin
          if (mode_eff == MODE_BOUNCE && at_limit) begin
            // Reversal wins over a same-cycle direction press: both leave us reversed.
            dir_d    = ~dir_q;
            step_dir = ~dir_q;
            step_d   = 1'b1;
          end else if (mode_eff == MODE_STOP && at_limit) begin
            state_d = DONE;
          end else begin
            step_d = 1'b1;
          end
        end
      end
      PAUSE: begin
        if (run_p) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      DONE: begin
        if (run_p) begin
          state_d = IDLE;
          clear_d = 1'b1;
          dir_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // While stepping, `up` shows the direction of that step; otherwise the live direction.
    up_d = step_d ? step_dir : dir_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
      up_q    <= 1'b1;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      up_q    <= up_d;
      clear_q <= clear_d;
    end
  end

  assign step    = step_q;
  assign up      = up_q;
  assign clear   = clear_q;
  assign busy    = (state_q == RUN);
  assign state_o = state_q;

endmodule
